// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one instruction-memory request at a time from the PC index
// and buffers returned words with their addresses in a DEPTH-entry FIFO for decode.
module inst_fetch #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] pc_in,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic            inst_valid,
    output logic [31:0]     inst_out,
    output logic [SIZE-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    typedef struct packed {
        logic [31:0]     data;
        logic [SIZE-1:0] pc;
    } entry_t;

    state_t          state, state_nxt;
    logic            req_nxt;
    logic            issue;
    logic            push;
    logic            pop;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    entry_t          mem [DEPTH];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        req_nxt    = imem_req;
        issue      = 1'b0;
        pc_advance = 1'b0;
        case (state)
            IDLE: begin
                // Issuing only below FULL reserves the slot the ack will need.
                if (count < FULL && !flush) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    issue     = 1'b1;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_nxt  = IDLE;
                    req_nxt    = 1'b0;
                    pc_advance = !flush;
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    assign push = pc_advance;
    assign pop  = inst_valid && inst_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state    <= state_nxt;
            imem_req <= req_nxt;
            if (issue) begin
                imem_addr <= pc_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is reset so the head outputs read zero out of reset rather than X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[tail] <= '{data: imem_data, pc: imem_addr};
        end
    end

    assign inst_valid = (count != '0);
    assign inst_out   = mem[head].data;
    assign inst_pc    = mem[head].pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a latency-configurable memory, an external PC register
// and a queue-based reference of the instruction buffer and request protocol.
module tb_inst_fetch;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic [31:0] pc_in, imem_addr, imem_data, inst_out, inst_pc;
    logic        pc_advance, flush, imem_req, imem_ack, inst_valid, inst_ready;

    inst_fetch #(.SIZE(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        q[$];
    int          req_log_cyc[$];
    logic [31:0] req_log_addr[$];
    logic [31:0] salt, target, prev_addr, prev_pc;
    bit          exp_req, prev_req, poisoned, s_adv, s_flush;
    bit          rand_mode, ready_follow, lat_rand, spur_en;
    int          cyc, age, cur_lat, lat_fixed, n_push;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Protocol and buffer reference: evaluated mid-cycle, then advanced to the next cycle.
    task automatic check_cycle();
        int   sz;
        bit   exp_adv;
        ent_t e;
        sz = q.size();
        check("imem_req", imem_req, exp_req);
        if (imem_req && prev_req) check("addr_hold", imem_addr, prev_addr);
        if (imem_req && !prev_req) begin
            check("addr_issue", imem_addr, prev_pc);
            req_log_addr.push_back(imem_addr);
            req_log_cyc.push_back(cyc);
        end
        exp_adv = imem_req && imem_ack && !flush && !poisoned;
        check("pc_advance", pc_advance, exp_adv);
        check("inst_valid", inst_valid, sz != 0);
        if (sz != 0) begin
            check("inst_out", inst_out, q[0].data);
            check("inst_pc", inst_pc, q[0].pc);
        end
        if (flush) begin
            q.delete();
        end else begin
            if (sz != 0 && inst_ready) void'(q.pop_front());
            if (exp_adv) begin
                e.pc   = imem_addr;
                e.data = word(imem_addr);
                q.push_back(e);
                n_push++;
            end
        end
        if (imem_req && imem_ack) poisoned = 1'b0;
        else if (imem_req && flush) poisoned = 1'b1;
        exp_req   = imem_req ? !imem_ack : (sz < DEPTH && !flush);
        prev_req  = imem_req;
        prev_addr = imem_addr;
        prev_pc   = pc_in;
        s_adv     = pc_advance;
        s_flush   = flush;
    endtask

    // One clock: check mid-cycle, then update PC, memory and random inputs just after the edge.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        cyc++;
        #1;
        if (s_flush) pc_in = target;
        else if (s_adv) pc_in = pc_in + 32'd4;
        if (imem_req) begin
            age++;
            if (age == 1) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
            imem_ack = (age > cur_lat);
        end else begin
            age      = 0;
            imem_ack = spur_en && ($urandom_range(0, 2) == 0);
        end
        imem_data = (imem_ack && imem_req) ? word(imem_addr) : $urandom;
        if (rand_mode) begin
            inst_ready = ($urandom_range(0, 99) < 60);
            flush      = ($urandom_range(0, 99) < 5);
            target     = $urandom & 32'hFFFF_FFFC;
        end
        if (ready_follow) inst_ready = imem_ack;
    endtask

    task automatic model_reset();
        q.delete();
        req_log_cyc.delete();
        req_log_addr.delete();
        poisoned = 1'b0;
        exp_req  = 1'b0;
        prev_req = 1'b0;
        s_adv    = 1'b0;
        s_flush  = 1'b0;
        age      = 0;
        cyc      = 0;
    endtask

    task automatic wait_req_rise(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(imem_req && !prev_req) && n < budget);
        check(tag, imem_req && !prev_req, 1'b1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n, base, snap;
        salt         = $urandom;
        rst          = 1'b0;
        pc_in        = 32'h0;
        flush        = 1'b0;
        inst_ready   = 1'b1;
        imem_ack     = 1'b1;
        imem_data    = 32'h0;
        target       = 32'h0;
        rand_mode    = 1'b0;
        ready_follow = 1'b0;
        lat_rand     = 1'b0;
        spur_en      = 1'b0;
        lat_fixed    = 0;
        n_push       = 0;
        model_reset();

        // Reset state, with a stray ack that must not produce a pc_advance.
        #3;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_adv", pc_advance, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        imem_ack = 1'b0;

        // Zero-wait memory: requests to 0,4,8 on cycles 1,3,5.
        ticks(10);
        check("zw_req_count", req_log_addr.size() >= 3, 1'b1);
        if (req_log_addr.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("zw_addr", req_log_addr[i], 32'(4 * i));
                check("zw_cycle", req_log_cyc[i], 2 * i + 1);
            end
        end

        // Backpressure with 3-cycle memory: fill DEPTH entries then stall.
        inst_ready = 1'b0;
        lat_fixed  = 2;
        ticks(40);
        check("full_req_low", imem_req, 1'b0);
        check("full_valid", inst_valid, 1'b1);
        base = req_log_addr.size();
        ticks(10);
        check("full_no_req", req_log_addr.size() - base, 0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        base = req_log_addr.size();
        ticks(20);
        check("one_pop_one_req", req_log_addr.size() - base, 1);

        // Flush in the first cycle of a 3-cycle request: DROP, then redirect to 0x100.
        inst_ready = 1'b1;
        wait_req_rise("drop_setup_timeout", 10);
        flush  = 1'b1;
        target = 32'h100;
        tick();
        flush      = 1'b0;
        inst_ready = 1'b0;
        check("drop_fifo_empty", inst_valid, 1'b0);
        snap = n_push;
        wait_req_rise("drop_redirect_timeout", 20);
        check("drop_redirect_addr", imem_addr, 32'h100);
        check("drop_no_push", n_push - snap, 0);

        // Flush coincident with ack while two entries are buffered.
        n = 0;
        while (q.size() != 2 && n < 30) begin tick(); n++; end
        check("two_buffered_timeout", q.size(), 2);
        n = 0;
        while (!(imem_req && imem_ack) && n < 10) begin tick(); n++; end
        check("ack_wait_timeout", imem_req && imem_ack, 1'b1);
        flush  = 1'b1;
        target = 32'h300;
        tick();
        flush = 1'b0;
        check("ack_flush_adv", s_adv, 1'b0);
        check("ack_flush_empty", inst_valid, 1'b0);
        wait_req_rise("ack_flush_redirect_timeout", 10);
        check("ack_flush_redirect_addr", imem_addr, 32'h300);

        // Push and pop together at DEPTH-1 across pointer wrap.
        lat_fixed = 0;
        n = 0;
        while (q.size() != DEPTH - 1 && n < 20) begin tick(); n++; end
        check("fill3_timeout", q.size(), DEPTH - 1);
        ready_follow = 1'b1;
        snap = n_push;
        ticks(20);
        check("wrap_pushes", n_push - snap >= 6, 1'b1);
        n = 0;
        while (imem_req && n < 4) begin tick(); n++; end
        ready_follow = 1'b0;
        inst_ready   = 1'b0;
        base = req_log_addr.size();
        ticks(15);
        check("wrap_count_held", req_log_addr.size() - base, 1);

        // Randomized traffic: latency 0..3, random ready, flushes, stray acks.
        rand_mode = 1'b1;
        lat_rand  = 1'b1;
        spur_en   = 1'b1;
        ticks(500);
        rand_mode  = 1'b0;
        lat_rand   = 1'b0;
        spur_en    = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b1;
        ticks(10);

        // Reset while a request is outstanding.
        lat_fixed = 3;
        wait_req_rise("rst_mid_setup_timeout", 10);
        tick();
        #2;
        rst      = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("midrst_req", imem_req, 1'b0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_valid", inst_valid, 1'b0);
        check("midrst_inst_out", inst_out, 32'h0);
        check("midrst_inst_pc", inst_pc, 32'h0);
        check("midrst_adv", pc_advance, 1'b0);
        pc_in = 32'h2000;
        @(posedge clk);
        #1;
        check("midrst_hold_req", imem_req, 1'b0);
        rst      = 1'b1;
        imem_ack = 1'b0;
        model_reset();
        wait_req_rise("restart_timeout", 5);
        check("restart_addr", imem_addr, 32'h2000);
        check("restart_cycle", cyc, 1);
        lat_fixed = 1;
        ticks(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the consumer of the program-counter register's output index. Samples the current PC value, issues one request at a time to instruction memory over a req/ack handshake, and buffers returned instructions with their addresses in a DEPTH-entry FIFO. Presents them to decode over valid/ready. Pulses `pc_advance` so the PC next-index logic loads PC+4, and discards stale work on `flush` (branch/jump redirect).

## Interface
- `SIZE`, 32, address (index) width
- `DEPTH`, 4, FIFO entries; power of 2, ≥2

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `pc_in`  in  SIZE  current index from PC register
- `pc_advance`  out  1  one-cycle pulse: PC must load pc_in+4 at the next edge
- `flush`  in  1  redirect; PC loads target externally this cycle
- `imem_req`  out  1  instruction memory request
- `imem_addr`  out  SIZE  request address, stable while `imem_req`=1
- `imem_ack`  in  1  memory response valid this cycle
- `imem_data`  in  32  instruction word, valid when `imem_ack`=1
- `inst_valid`  out  1  FIFO head valid
- `inst_out`  out  32  head instruction
- `inst_pc`  out  SIZE  head instruction address
- `inst_ready`  in  1  decode accepts head

## Operation
- States: IDLE, REQ, DROP.
- IDLE → REQ when `count`<DEPTH and `flush`=0: latch `imem_addr`<=pc_in, `imem_req`<=1. Otherwise stay in IDLE.
- REQ, `imem_ack`=1, `flush`=0:
  - write {imem_data, imem_addr} at tail
  - `pc_advance`=1 (combinational, this cycle only)
  - `imem_req`<=0; → IDLE
- REQ, `imem_ack`=1, `flush`=1: data discarded, `pc_advance`=0, `imem_req`<=0, → IDLE.
- REQ, `imem_ack`=0, `flush`=1: → DROP, `imem_req` stays 1 with the same address.
- DROP: hold `imem_req`. On `imem_ack`, discard data, `imem_req`<=0, → IDLE. `flush` in DROP has no additional effect.
- `pc_advance` is never asserted in IDLE or DROP, or while `flush`=1.
- Memory protocol:
  - `imem_req` is held with constant `imem_addr` until `imem_ack` is sampled high.
  - At most one request is outstanding.
  - `imem_ack` while `imem_req`=0 is ignored.
- FIFO:
  - `inst_valid` = (count≠0); `inst_out`/`inst_pc` driven from the head entry.
  - Pop when `inst_valid`&`inst_ready`&!`flush`.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Space is reserved at issue (count<DEPTH with one outstanding), so an ack always finds a free slot.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- `flush`=1 at an edge: head, tail and count are cleared to 0. No push or pop takes effect in that cycle.

## Timing
- Reset (`rst`=0, immediate, asynchronous):
  - state IDLE
  - `imem_req`=0, `imem_addr`=0
  - count/pointers=0, `inst_valid`=0
  - FIFO storage zeroed, so `inst_out`=0 and `inst_pc`=0
  - `pc_advance`=0
- Reset mid-request abandons the request. `imem_req` falls immediately, and the memory must tolerate an unacknowledged drop.
- First request: earliest `imem_req`=1 is the cycle after the first edge with `rst`=1.
- With zero-wait memory (ack in the same cycle as req), the sequence repeats every 2 cycles: REQ (ack, push, pc_advance), IDLE, REQ. Throughput is 1 instruction per 2 cycles.
- A pushed entry is visible on `inst_valid` in the cycle after the ack.
- Flush: `inst_valid`=0 in the cycle after the flush edge. The first post-flush request issues 1 cycle after the flush when starting from IDLE or REQ+ack, and the cycle after the ack when in DROP. In both cases it uses the redirected `pc_in`.

## Test plan
- Reset then zero-wait memory, `pc_in` starting 0x0, `inst_ready`=1 → requests to 0x0, 0x4, 0x8 on cycles 1, 3, 5. One `pc_advance` pulse per ack. `inst_pc`/`inst_out` match the memory contents in order.
- `inst_ready`=0, 3-cycle memory latency → exactly DEPTH (4) entries are filled, then `imem_req` stays 0. Raising `inst_ready` for 1 cycle yields exactly one new request.
- `flush` in REQ cycle 1 of a 3-cycle ack, with `pc_in` redirected to 0x100 → DROP, no push, no `pc_advance`. The next request goes to 0x100; the FIFO is empty the cycle after the flush.
- `flush` coincident with `imem_ack` and 2 entries buffered → data dropped, count=0, `pc_advance`=0, next request addr=redirected `pc_in`.
- Simultaneous push and pop at count=DEPTH−1 across pointer wrap (≥6 instructions through DEPTH=4) → count stays constant, order preserved.
- `rst` asserted low while `imem_req`=1 → all outputs zero immediately. On release, fetch restarts from the current `pc_in`.
